// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: op codes, FSM state
// encoding, widths and the request/result payload structs.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned STATE_W = 2;

  // ALU control codes
  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT = 3'b111;

  // FSM state encoding
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_EXEC = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

  // Captured request: operation, operands and owning port
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              id;
  } alu_req_t;

  // ALU result payload
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              err;
  } alu_res_t;

endpackage

// File: rtl/alu_arbiter_exec.sv
// Combinational ALU core.
// Ports: op/a/b in; data_c (result), zero_c (result is zero),
// err_c (op code undefined) out. Undefined codes yield a zero result.
module alu_exec
  import alu_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] data_c,
  output logic              zero_c,
  output logic              err_c
);

  // Operation decode; arithmetic wraps modulo 2^32
  always_comb begin
    data_c = '0;
    err_c  = 1'b0;
    case (op)
      OP_ADD:  data_c = a + b;
      OP_SUB:  data_c = a - b;
      OP_AND:  data_c = a & b;
      OP_OR:   data_c = a | b;
      OP_SLT:  data_c = DATA_W'($signed(a) < $signed(b));
      default: err_c  = 1'b1;
    endcase
  end

  assign zero_c = (data_c == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port ALU arbiter: grants one requester at a time, runs the op through
// alu_exec one cycle after acceptance and holds the response until consumed.
// Ports: clk_i, rst_i (async, active-high); reqN_valid_i/op_i/a_i/b_i and
// reqN_ready_o per requester; rsp_valid_o/id_o/data_o/zero_o/err_o with
// rsp_ready_i toward the consumer; busy_o while not idle.
// RR_EN=1 alternates ties between ports, RR_EN=0 always favours port 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
)
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [OP_W-1:0]   req1_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic              req1_ready_o,
  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_zero_o,
  output logic              rsp_err_o,
  input  logic              rsp_ready_i,
  output logic              busy_o
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               last_q;     // port served most recently
  logic               grant_c;
  logic               accept_c;
  logic               rsp_done_c;
  alu_req_t           req_q;
  alu_req_t           req_d;
  alu_res_t           res_c;

  // Grant selection; ties go to the port not served last when round-robin
  always_comb begin
    grant_c = req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      grant_c = RR_EN ? ~last_q : 1'b0;
    end
  end

  // Next state and handshake decode
  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    rsp_done_c   = 1'b0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Readies are masked during reset so nothing appears accepted
        accept_c     = (req0_valid_i || req1_valid_i) && !rst_i;
        req0_ready_o = accept_c && !grant_c;
        req1_ready_o = accept_c && grant_c;
        if (accept_c) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        rsp_done_c = rsp_ready_i;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Operand mux for the granted port
  always_comb begin
    req_d = grant_c ? alu_req_t'{op: req1_op_i, a: req1_a_i, b: req1_b_i, id: 1'b1}
                    : alu_req_t'{op: req0_op_i, a: req0_a_i, b: req0_b_i, id: 1'b0};
  end

  alu_exec u_alu_exec (
    .op     (req_q.op),
    .a      (req_q.a),
    .b      (req_q.b),
    .data_c (res_c.data),
    .zero_c (res_c.zero),
    .err_c  (res_c.err)
  );

  // Request capture, response registers and last-served pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q       <= '0;
      last_q      <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= 1'b0;
      rsp_data_o  <= '0;
      rsp_zero_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      busy_o <= (state_d != ST_IDLE);
      if (accept_c) req_q <= req_d;
      if (state_q == ST_EXEC) begin
        rsp_valid_o <= 1'b1;
        rsp_id_o    <= req_q.id;
        rsp_data_o  <= res_c.data;
        rsp_zero_o  <= res_c.zero;
        rsp_err_o   <= res_c.err;
      end
      if (rsp_done_c) begin
        rsp_valid_o <= 1'b0;
        last_q      <= rsp_id_o;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench: a round-robin and a fixed-priority arbiter
// share one stimulus stream and are compared against a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rsp_ready;
  logic [2:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;

  logic        r0_rr, r1_rr, rv_rr, id_rr, zero_rr, err_rr, busy_rr;
  logic [31:0] data_rr;
  logic        r0_fp, r1_fp, rv_fp, id_fp, zero_fp, err_fp, busy_fp;
  logic [31:0] data_fp;

  int n_checks = 0;
  int n_errors = 0;
  logic last_rr, last_fp;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(r0_rr),
    .req1_valid_i(v1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(r1_rr),
    .rsp_valid_o(rv_rr), .rsp_id_o(id_rr), .rsp_data_o(data_rr), .rsp_zero_o(zero_rr),
    .rsp_err_o(err_rr), .rsp_ready_i(rsp_ready), .busy_o(busy_rr)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(r0_fp),
    .req1_valid_i(v1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(r1_fp),
    .rsp_valid_o(rv_fp), .rsp_id_o(id_fp), .rsp_data_o(data_fp), .rsp_zero_o(zero_fp),
    .rsp_err_o(err_fp), .rsp_ready_i(rsp_ready), .busy_o(busy_fp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which port wins given the valids, arbitration mode and last-served port
  function automatic logic pick(input logic pv0, input logic pv1, input logic rr, input logic last);
    if (pv0 && pv1) return rr ? !last : 1'b0;
    return pv1;
  endfunction

  // Reference ALU straight from the op-code table
  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic e);
    e = 1'b0;
    case (op)
      3'b010:  d = a + b;
      3'b110:  d = a - b;
      3'b000:  d = a & b;
      3'b001:  d = a | b;
      3'b111:  d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin d = 32'd0; e = 1'b1; end
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Random request-side activity; must be ignored while busy
  task automatic scramble();
    v0  = 1'($urandom); v1 = 1'($urandom);
    op0 = 3'($urandom); op1 = 3'($urandom);
    a0  = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
  endtask

  task automatic check_rsp(input string tag, input logic gr, input logic gf,
                           input logic [31:0] dr, input logic er,
                           input logic [31:0] df, input logic ef);
    check({tag, "_valid_rr"}, rv_rr, 1);
    check({tag, "_id_rr"},    id_rr, gr);
    check({tag, "_data_rr"},  data_rr, dr);
    check({tag, "_zero_rr"},  zero_rr, dr == 0);
    check({tag, "_err_rr"},   err_rr, er);
    check({tag, "_valid_fp"}, rv_fp, 1);
    check({tag, "_id_fp"},    id_fp, gf);
    check({tag, "_data_fp"},  data_fp, df);
    check({tag, "_zero_fp"},  zero_fp, df == 0);
    check({tag, "_err_fp"},   err_fp, ef);
    check({tag, "_busy_rr"},  busy_rr, 1);
    check({tag, "_busy_fp"},  busy_fp, 1);
    check({tag, "_rdy_rr"},   {r1_rr, r0_rr}, 0);
    check({tag, "_rdy_fp"},   {r1_fp, r0_fp}, 0);
  endtask

  // One request cycle; if accepted, follows it through EXEC and RESP,
  // holding rsp_ready low for 'hold' RESP cycles. Entered shortly after an edge.
  task automatic do_txn(input logic iv0, input logic iv1,
                        input logic [2:0] iop0, input logic [31:0] ia0, input logic [31:0] ib0,
                        input logic [2:0] iop1, input logic [31:0] ia1, input logic [31:0] ib1,
                        input int hold);
    logic gr, gf, er, ef;
    logic [31:0] dr, df;
    v0 = iv0; v1 = iv1; op0 = iop0; a0 = ia0; b0 = ib0; op1 = iop1; a1 = ia1; b1 = ib1;
    rsp_ready = 1'b0;
    #1;
    gr = pick(iv0, iv1, 1'b1, last_rr);
    gf = pick(iv0, iv1, 1'b0, last_fp);
    check("idle_rdy0_rr", r0_rr, iv0 && !gr);
    check("idle_rdy1_rr", r1_rr, iv1 && gr);
    check("idle_rdy0_fp", r0_fp, iv0 && !gf);
    check("idle_rdy1_fp", r1_fp, iv1 && gf);
    check("idle_busy", {busy_fp, busy_rr}, 0);
    check("idle_rv",   {rv_fp, rv_rr}, 0);
    if (!(iv0 || iv1)) begin
      @(posedge clk); #1;
      check("noreq_busy", {busy_fp, busy_rr}, 0);
      return;
    end
    if (gr) ref_alu(iop1, ia1, ib1, dr, er); else ref_alu(iop0, ia0, ib0, dr, er);
    if (gf) ref_alu(iop1, ia1, ib1, df, ef); else ref_alu(iop0, ia0, ib0, df, ef);
    @(posedge clk); #1;
    scramble(); #1;
    check("exec_busy", {busy_fp, busy_rr}, 2'b11);
    check("exec_rv",   {rv_fp, rv_rr}, 0);
    check("exec_rdy",  {r1_fp, r0_fp, r1_rr, r0_rr}, 0);
    @(posedge clk); #1;
    scramble(); #1;
    check_rsp("resp", gr, gf, dr, er, df, ef);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      scramble(); #1;
      check_rsp("hold", gr, gf, dr, er, df, ef);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; v0 = 1'b0; v1 = 1'b0; #1;
    check("done_busy", {busy_fp, busy_rr}, 0);
    check("done_rv",   {rv_fp, rv_rr}, 0);
    last_rr = gr;
    last_fp = gf;
  endtask

  // Reset asserted between edges while in EXEC (phase 0) or RESP (phase 1)
  task automatic reset_mid(input int phase);
    v0 = 1'b1; v1 = 1'b1; op0 = 3'b010; op1 = 3'b010;
    a0 = 32'd3; b0 = 32'd4; a1 = 32'd5; b1 = 32'd6; rsp_ready = 1'b0;
    @(posedge clk); #1;
    if (phase == 1) begin @(posedge clk); #1; end
    v0 = 1'b1; v1 = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_rv",   {rv_fp, rv_rr}, 0);
    check("rst_busy", {busy_fp, busy_rr}, 0);
    check("rst_data", data_rr | data_fp, 0);
    check("rst_flags", {id_rr, zero_rr, err_rr, id_fp, zero_fp, err_fp}, 0);
    check("rst_rdy",  {r1_fp, r0_fp, r1_rr, r0_rr}, 0);
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rr = 1'b1;
    last_fp = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    v0 = 1'b1; v1 = 1'b1; op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    last_rr = 1'b1; last_fp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("por_rv",    {rv_fp, rv_rr}, 0);
    check("por_busy",  {busy_fp, busy_rr}, 0);
    check("por_data",  data_rr | data_fp, 0);
    check("por_flags", {id_rr, zero_rr, err_rr, id_fp, zero_fp, err_fp}, 0);
    check("por_rdy",   {r1_fp, r0_fp, r1_rr, r0_rr}, 0);
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Ties with rsp_ready high: RR alternates from port 0, fixed stays on 0
    for (int i = 0; i < 4; i++)
      do_txn(1, 1, 3'b010, 32'(i), 32'd1, 3'b110, 32'(i), 32'd1, 0);

    // Single-port add
    do_txn(1, 0, 3'b010, 32'd5, 32'd7, 3'b000, 32'd0, 32'd0, 0);
    // Corner results
    do_txn(1, 0, 3'b110, 32'd9, 32'd9, 3'b000, 32'd0, 32'd0, 0);
    do_txn(0, 1, 3'b000, 32'd0, 32'd0, 3'b111, 32'hFFFF_FFFF, 32'd1, 0);
    do_txn(1, 0, 3'b111, 32'd1, 32'hFFFF_FFFF, 3'b000, 32'd0, 32'd0, 0);
    do_txn(0, 1, 3'b000, 32'd0, 32'd0, 3'b010, 32'hFFFF_FFFF, 32'd1, 0);
    // Backpressure
    do_txn(1, 1, 3'b001, 32'hF0, 32'h0F, 3'b000, 32'hFF, 32'h3C, 5);
    // Undefined op
    do_txn(1, 0, 3'b011, 32'd1, 32'd2, 3'b000, 32'd0, 32'd0, 0);
    do_txn(0, 1, 3'b000, 32'd0, 32'd0, 3'b101, 32'd7, 32'd7, 1);

    // Reset mid-EXEC and mid-RESP, each followed by a tie that port 0 must win
    reset_mid(0);
    do_txn(1, 1, 3'b010, 32'd10, 32'd20, 3'b010, 32'd30, 32'd40, 0);
    check("post_rst_rr_last", last_rr, 0);
    reset_mid(1);
    do_txn(1, 1, 3'b110, 32'd1, 32'd2, 3'b110, 32'd3, 32'd4, 0);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      do_txn(1'($urandom), 1'($urandom),
             3'($urandom), rand_word(), rand_word(),
             3'($urandom), rand_word(), rand_word(),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
